fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Owns the fetch-side program counter and sequences each instruction fetch over a req/ack + rvalid
//  instruction-memory interface, then hands the word to decode over a valid/ready handshake.
//  Jump and branch redirects from decode override sequential PC+4 and squash in-flight fetches.
//  A watchdog flags a memory that never responds. Sits between imem and the decode stage.
// PARAMETERS
//  ADDR_W        32   PC and memory address width
//  RESET_VECTOR  0    PC value loaded on reset; bits [1:0] must be 00
//  TIMEOUT       64   max cycles in WAIT before fetch_err; minimum 2
// PORTS
//  clk            in   1       clock; all state changes on rising edge
//  reset          in   1       asynchronous, active-high reset
//  stall          in   1       1 = do not start a new fetch
//  redirect_en    in   1       1-cycle pulse: taken jump/branch
//  redirect_addr  in   ADDR_W  redirect target; bits [1:0] ignored and forced to 00
//  imem_req       out  1       fetch request
//  imem_addr      out  ADDR_W  fetch address; equals pc while imem_req=1
//  imem_ack       in   1       memory accepted the request this cycle (req & ack)
//  imem_rvalid    in   1       read data valid
//  imem_rdata     in   32      instruction word
//  instr_valid    out  1       instr_out/instr_pc valid for decode
//  instr_ready    in   1       decode accepts (valid & ready = transfer)
//  instr_out      out  32      fetched instruction
//  instr_pc       out  ADDR_W  address instr_out was fetched from
//  fetch_err      out  1       sticky: watchdog expired
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_VECTOR, imem_req=0, instr_valid=0, instr_out=0, instr_pc=0,
//   fetch_err=0, discard=0, wd_cnt=0. Reset mid-transaction drops everything; late rvalid is ignored.
//  imem_req=1 only in REQ; instr_valid=1 only in HOLD. Both outputs are decoded from state registers.
//  IDLE: !stall -> REQ.
//  REQ: drive imem_addr=pc. On ack: pend_pc<=pc, wd_cnt<=0, go to WAIT. Stall is ignored in REQ.
//  WAIT: wd_cnt++.
//   - rvalid & !discard: instr_out<=rdata, instr_pc<=pend_pc, pc<=pc+4, go to HOLD.
//   - rvalid & discard: drop the word, discard<=0, go to REQ if !stall, else IDLE.
//   - wd_cnt==TIMEOUT-1 & !rvalid: fetch_err<=1, go to ERR.
//  HOLD: on instr_ready, go to REQ if !stall, else IDLE. Outputs hold stable until the transfer.
//  ERR: terminal until reset. imem_req=0, instr_valid=0, and redirects are ignored.
//  Redirect (priority over PC+4 in every state except ERR; new pc = {redirect_addr[ADDR_W-1:2],2'b00}):
//   - IDLE: pc updated.
//   - REQ without ack: pc updated; imem_addr changes the next cycle.
//   - REQ with ack same cycle: pc updated, discard<=1 (accepted fetch is stale).
//   - WAIT: pc updated, discard<=1. If rvalid arrives the same cycle, drop it and apply the redirect.
//   - HOLD: squash; instr_valid falls next cycle even if instr_ready=1, then go to REQ/IDLE per stall.
//  Arithmetic: pc+4 is modulo 2^ADDR_W, so 0xFFFFFFFC wraps to 0x0. pc[1:0] is always 00.
//  Latency, zero-wait memory (ack with req, rvalid next cycle): REQ->WAIT->HOLD.
//   - instr_valid rises 2 cycles after the req cycle.
//   - Steady state: 1 instruction every 3 cycles with instr_ready=1.
// STRUCTURE
//  Shared package fetch_pkg:
//   - state enum IDLE/REQ/WAIT/HOLD/ERR (3 bits)
//   - PC_INCR=4
//   - default RESET_VECTOR
//  Sub-module fetch_watchdog: wd_cnt counter, clear/enable inputs, expire output at TIMEOUT-1.
//  All other logic is flat in fetch_sequencer: FSM, pc/pend_pc/discard registers, output registers.
// TESTING
//  1. Reset release, stall=0, zero-wait memory -> first imem_req with addr 0x0.
//     instr_pc sequence 0x0,0x4,0x8, one instr_valid per 3 cycles.
//  2. instr_ready held 0 for 5 cycles in HOLD -> instr_valid, instr_out, instr_pc stable.
//     No new imem_req until the transfer.
//  3. redirect_en to 0x100 while in WAIT -> returning word dropped, never shown to decode.
//     Next imem_addr=0x100, next instr_pc=0x100.
//  4. redirect_en to 0x203 coincident with rvalid in WAIT -> word dropped; next fetch addr 0x200.
//  5. pc=0xFFFFFFFC fetch completes -> next imem_addr=0x0.
//  6. Memory never asserts rvalid (TIMEOUT=8) -> fetch_err=1 after 8 WAIT cycles, imem_req=0.
//     Stays in ERR despite redirect; async reset clears fetch_err immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Types and constants shared by the fetch sequencer and its watchdog.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } fetch_state_e;

  localparam int unsigned PC_INCR              = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts cycles spent waiting on instruction memory and flags when the budget runs out.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] wd_cnt_q;
  logic [CNT_W-1:0] wd_cnt_d;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (clear) begin
      wd_cnt_d = '0;
    end else if (enable) begin
      wd_cnt_d = wd_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign expire = (wd_cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-side PC owner: sequences imem req/ack/rvalid fetches and presents words to decode,
// with jump/branch redirects squashing stale fetches and a watchdog for a silent memory.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
  parameter int unsigned        TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fetch_err
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              discard_q, discard_d;
  logic [31:0]       instr_out_q, instr_out_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              fetch_err_q, fetch_err_d;

  logic              wd_expire;
  logic [ADDR_W-1:0] redir_pc;
  logic [ADDR_W-1:0] pc_inc;
  fetch_state_e      resume_state;
  logic              unused_redirect_lsb;

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != WAIT),
    .enable (state_q == WAIT),
    .expire (wd_expire)
  );

  assign redir_pc            = {redirect_addr[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_addr[1:0];
  assign pc_inc              = pc_q + ADDR_W'(PC_INCR);
  assign resume_state        = stall ? IDLE : REQ;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    discard_d   = discard_q;
    instr_out_d = instr_out_q;
    instr_pc_d  = instr_pc_q;
    fetch_err_d = fetch_err_q;

    unique case (state_q)
      IDLE: begin
        if (redirect_en) pc_d = redir_pc;
        if (!stall)      state_d = REQ;
      end

      REQ: begin
        if (redirect_en) pc_d = redir_pc;
        if (imem_ack) begin
          pend_pc_d = pc_q;
          state_d   = WAIT;
          // A redirect alongside the accept means the word now in flight is stale.
          if (redirect_en) discard_d = 1'b1;
        end
      end

      WAIT: begin
        if (redirect_en) begin
          pc_d = redir_pc;
          if (imem_rvalid) begin
            discard_d = 1'b0;
            state_d   = resume_state;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = resume_state;
          end else begin
            instr_out_d = imem_rdata;
            instr_pc_d  = pend_pc_q;
            pc_d        = pc_inc;
            state_d     = HOLD;
          end
        end
        if (wd_expire && !imem_rvalid) begin
          fetch_err_d = 1'b1;
          state_d     = ERR;
        end
      end

      HOLD: begin
        if (redirect_en) begin
          pc_d    = redir_pc;
          state_d = resume_state;
        end else if (instr_ready) begin
          state_d = resume_state;
        end
      end

      ERR: begin
        state_d = ERR;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_VECTOR;
      pend_pc_q   <= '0;
      discard_q   <= 1'b0;
      instr_out_q <= '0;
      instr_pc_q  <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      discard_q   <= discard_d;
      instr_out_q <= instr_out_d;
      instr_pc_q  <= instr_pc_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_err   = fetch_err_q;

endmodule
